// File: rtl/wb_cmd_master.sv
// Wishbone single-beat initiator: queues valid/ready register commands in a small FIFO,
// runs one bus cycle per command with an ack timeout and returns each result in order.
module wb_cmd_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_sel,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_we,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [31:0]           wb_dat_o,
    input  logic [31:0]           wb_dat_i,
    output logic                  wb_we,
    output logic [3:0]            wb_sel,
    output logic                  wb_stb,
    output logic                  wb_cyc,
    input  logic                  wb_ack,
    output logic                  busy
);
    localparam int ENTRY_W = ADDR_WIDTH + 37;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                  state_reg;
    logic [ENTRY_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [CNT_W-1:0]        count_reg;
    logic                    push;
    logic                    pop;

    logic [ADDR_WIDTH-1:0]   wb_addr_reg;
    logic [31:0]             wb_dat_reg;
    logic                    wb_we_reg;
    logic [3:0]              wb_sel_reg;
    logic                    wb_stb_reg;
    logic [15:0]             tmo_cnt_reg;
    logic                    rsp_valid_reg;
    logic                    rsp_we_reg;
    logic [31:0]             rsp_rdata_reg;
    logic                    rsp_err_reg;

    // Ready depends only on the registered count, so no input-to-output path exists.
    assign cmd_ready = (count_reg < DEPTH_C);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_reg == IDLE) && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {cmd_we, cmd_sel, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wb_addr_reg   <= '0;
            wb_dat_reg    <= '0;
            wb_we_reg     <= 1'b0;
            wb_sel_reg    <= '0;
            wb_stb_reg    <= 1'b0;
            tmo_cnt_reg   <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_we_reg    <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        {wb_we_reg, wb_sel_reg, wb_addr_reg, wb_dat_reg} <= fifo_mem[rd_ptr_reg];
                        wb_stb_reg  <= 1'b1;
                        tmo_cnt_reg <= '0;
                        state_reg   <= REQ;
                    end
                end
                REQ: begin
                    // An ack in the last timeout cycle still completes the transfer cleanly.
                    if (wb_ack) begin
                        wb_stb_reg    <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_we_reg    <= wb_we_reg;
                        rsp_rdata_reg <= wb_we_reg ? 32'h0 : wb_dat_i;
                        rsp_err_reg   <= 1'b0;
                        state_reg     <= RESP;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        wb_stb_reg    <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_we_reg    <= wb_we_reg;
                        rsp_rdata_reg <= 32'h0;
                        rsp_err_reg   <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign wb_addr   = wb_addr_reg;
    assign wb_dat_o  = wb_dat_reg;
    assign wb_we     = wb_we_reg;
    assign wb_sel    = wb_sel_reg;
    assign wb_stb    = wb_stb_reg;
    assign wb_cyc    = wb_stb_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_we    = rsp_we_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;
    assign busy      = (state_reg != IDLE) || (count_reg != '0);

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master: a one-cycle-ack slave model, a register-file reference
// model, and independent bus/response monitors that pop expected entries as the DUT presents them.
`timescale 1ns/1ps
module tb_wb_cmd_master;
    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic [3:0]    cmd_sel = '0;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_we;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] wb_addr;
    logic [31:0]   wb_dat_o;
    logic [31:0]   wb_dat_i;
    logic          wb_we;
    logic [3:0]    wb_sel;
    logic          wb_stb;
    logic          wb_cyc;
    logic          wb_ack;
    logic          busy;

    always #5 clk = ~clk;

    wb_cmd_master #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .wb_addr(wb_addr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we(wb_we),
        .wb_sel(wb_sel), .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_ack(wb_ack), .busy(busy)
    );

    typedef struct { logic we; logic [31:0] rdata; logic err; } rsp_t;
    typedef struct { logic [AW-1:0] addr; logic we; logic [31:0] dat; logic [3:0] sel; int len; } bus_t;

    rsp_t        rsp_q[$];
    bus_t        bus_q[$];
    logic [31:0] model_mem [256];
    logic [31:0] slave_mem [256];
    int          write_cnt [256];

    int   n_cmp = 0;
    int   n_fail = 0;
    int   issued = 0;
    int   hs_count = 0;
    int   strobe_rises = 0;
    logic slave_ack_en = 1'b1;
    logic inject_ack = 1'b0;
    logic rand_ready = 1'b0;
    logic rsp_ready_man = 1'b1;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: a plain register file plus "does the slave answer" decides each result.
    function automatic void expect_cmd(input logic we, input logic [AW-1:0] addr,
                                       input logic [31:0] data, input logic [3:0] sel);
        rsp_t r;
        bus_t b;
        b.addr = addr; b.we = we; b.dat = data; b.sel = sel;
        b.len  = slave_ack_en ? 2 : TMO;
        r.we   = we;
        r.err  = !slave_ack_en;
        if (!slave_ack_en) begin
            r.rdata = 32'h0;
        end else if (we) begin
            r.rdata = 32'h0;
            model_mem[addr] = merge(model_mem[addr], data, sel);
        end else begin
            r.rdata = model_mem[addr];
        end
        bus_q.push_back(b);
        rsp_q.push_back(r);
        issued++;
    endfunction

    // Called just after a rising edge; leaves cmd_valid high so streams stay back-to-back.
    task automatic send(input logic we, input logic [AW-1:0] addr, input logic [31:0] data,
                        input logic [3:0] sel, input int budget);
        bit done = 1'b0;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = data; cmd_sel = sel;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                expect_cmd(we, addr, data, sel);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL cmd_accept: got no cmd_ready within %0d cycles, expected accept", budget);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic drain(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            if (hs_count == issued) ok = 1'b1;
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL drain: got %0d responses, expected %0d", hs_count, issued);
        end
    endtask

    // One-cycle-ack slave; inject_ack forces a stray ack regardless of the strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack   <= 1'b0;
            wb_dat_i <= '0;
        end else begin
            wb_ack <= 1'b0;
            if (inject_ack) begin
                wb_ack <= 1'b1;
            end else if (slave_ack_en && wb_stb && !wb_ack) begin
                wb_ack <= 1'b1;
                if (wb_we) begin
                    slave_mem[wb_addr] <= merge(slave_mem[wb_addr], wb_dat_o, wb_sel);
                    write_cnt[wb_addr] <= write_cnt[wb_addr] + 1;
                end else begin
                    wb_dat_i <= slave_mem[wb_addr];
                end
            end
        end
    end

    initial begin : ready_drv
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            rsp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : rsp_ready_man;
        end
    end

    initial begin : bus_mon
        logic stb_prev;
        bit   gap_valid;
        int   lo_len;
        int   hi_len;
        int   cur_len;
        bus_t b;
        stb_prev = 1'b0; gap_valid = 1'b0; lo_len = 0; hi_len = 0; cur_len = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stb_prev = 1'b0; gap_valid = 1'b0; lo_len = 0; hi_len = 0;
            end else begin
                if (wb_stb && !stb_prev) begin
                    strobe_rises++;
                    check("wb_cyc_on_strobe", 32'(wb_cyc), 32'd1);
                    if (gap_valid) begin
                        n_cmp++;
                        if (lo_len < 2) begin
                            n_fail++;
                            $display("FAIL strobe_gap: got %0d low cycles, expected >= 2", lo_len);
                        end
                    end
                    if (bus_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_strobe: got strobe at 0x%02h, expected none", wb_addr);
                        cur_len = 0;
                    end else begin
                        b = bus_q.pop_front();
                        check("wb_addr", 32'(wb_addr), 32'(b.addr));
                        check("wb_we", 32'(wb_we), 32'(b.we));
                        check("wb_dat_o", wb_dat_o, b.dat);
                        check("wb_sel", 32'(wb_sel), 32'(b.sel));
                        cur_len = b.len;
                    end
                    hi_len = 1;
                end else if (wb_stb) begin
                    hi_len++;
                end
                if (!wb_stb && stb_prev) begin
                    check("strobe_len", hi_len, cur_len);
                    check("wb_cyc_after_strobe", 32'(wb_cyc), 32'd0);
                    lo_len = 1;
                    gap_valid = 1'b1;
                end else if (!wb_stb) begin
                    lo_len++;
                end
                stb_prev = wb_stb;
            end
        end
    end

    initial begin : rsp_mon
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                hs_count++;
                if (rsp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_response: got rdata 0x%08h, expected none", rsp_rdata);
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_we", 32'(rsp_we), 32'(r.we));
                    check("rsp_rdata", rsp_rdata, r.rdata);
                    check("rsp_err", 32'(rsp_err), 32'(r.err));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish by 400us, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] v;
        int base_rise, base_iss, b0, b4, b8;
        logic prev_busy;
        bit got;

        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            model_mem[i] = v;
            slave_mem[i] = v;
        end
        model_mem[8] = 32'h0000_1234;
        slave_mem[8] = 32'h0000_1234;

        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_wb_stb", 32'(wb_stb), 32'd0);
        check("reset_wb_cyc", 32'(wb_cyc), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_wb_addr", 32'(wb_addr), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write with edge-exact latency.
        b0 = write_cnt[0];
        send(1'b1, 8'h00, 32'h0000_0001, 4'hF, 10);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("E1_wb_stb", 32'(wb_stb), 32'd1);
        check("E1_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("E2_wb_stb", 32'(wb_stb), 32'd1);
        check("E2_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("E3_wb_stb", 32'(wb_stb), 32'd0);
        check("E3_rsp_valid", 32'(rsp_valid), 32'd1);
        drain(20);
        check("single_write_count", 32'(write_cnt[0] - b0), 32'd1);

        send(1'b0, 8'h08, 32'($urandom), 4'hF, 10);
        cmd_valid = 1'b0;
        drain(20);

        // Backpressure: 5 accepted, the 6th stalls until responses drain.
        rsp_ready_man = 1'b0;
        @(posedge clk); #1;
        base_rise = strobe_rises;
        base_iss  = issued;
        for (int k = 0; k < 5; k++) begin
            send(k[0], 8'(8'h20 + 4 * k), 32'($urandom), 4'hF, 10);
        end
        cmd_we = 1'b0; cmd_addr = 8'h40; cmd_wdata = 32'h0; cmd_sel = 4'hF;
        @(negedge clk);
        check("full_cmd_ready", 32'(cmd_ready), 32'd0);
        repeat (6) @(negedge clk);
        check("accepted_while_full", 32'(issued - base_iss), 32'd5);
        check("bus_cycles_backpressure", 32'(strobe_rises - base_rise), 32'd1);
        @(posedge clk); #1;
        rsp_ready_man = 1'b1;
        send(1'b0, 8'h40, 32'h0, 4'hF, 60);
        cmd_valid = 1'b0;
        drain(120);

        // Timeout, then a stray late ack, then a normal command.
        slave_ack_en = 1'b0;
        send(1'b0, 8'h10, 32'h0, 4'hF, 10);
        cmd_valid = 1'b0;
        drain(60);
        base_rise = strobe_rises;
        @(posedge clk); #1;
        inject_ack = 1'b1;
        @(posedge clk); #1;
        inject_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("late_ack_rsp_valid", 32'(rsp_valid), 32'd0);
        check("late_ack_busy", 32'(busy), 32'd0);
        check("late_ack_no_strobe", 32'(strobe_rises - base_rise), 32'd0);
        slave_ack_en = 1'b1;
        send(1'b1, 8'h14, 32'($urandom), 4'h3, 10);
        cmd_valid = 1'b0;
        drain(20);

        // Reset while strobing with two commands queued.
        slave_ack_en = 1'b0;
        send(1'b0, 8'h30, 32'h0, 4'hF, 10);
        send(1'b0, 8'h34, 32'h0, 4'hF, 10);
        send(1'b0, 8'h38, 32'h0, 4'hF, 10);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_wb_stb", 32'(wb_stb), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        bus_q.delete();
        rsp_q.delete();
        #1;
        check("async_reset_wb_stb", 32'(wb_stb), 32'd0);
        check("async_reset_wb_cyc", 32'(wb_cyc), 32'd0);
        check("async_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("async_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        issued = hs_count;
        slave_ack_en = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        base_rise = strobe_rises;
        repeat (10) @(posedge clk);
        #1;
        check("post_reset_no_strobe", 32'(strobe_rises - base_rise), 32'd0);
        check("post_reset_busy", 32'(busy), 32'd0);

        // Streamed writes to the PWM register map: CTRL, FREQ_DIV, MOD_INDEX.
        b0 = write_cnt[8'h00]; b4 = write_cnt[8'h04]; b8 = write_cnt[8'h08];
        send(1'b1, 8'h00, 32'($urandom), 4'hF, 10);
        send(1'b1, 8'h04, 32'($urandom), 4'hF, 10);
        send(1'b1, 8'h08, 32'($urandom), 4'hF, 10);
        cmd_valid = 1'b0;
        prev_busy = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            prev_busy = busy;
            @(posedge clk); #1;
            if (hs_count == issued) got = 1'b1;
        end
        check("stream_done", 32'(got), 32'd1);
        check("busy_before_last_hs", 32'(prev_busy), 32'd1);
        check("busy_after_last_hs", 32'(busy), 32'd0);
        check("ctrl_writes", 32'(write_cnt[8'h00] - b0), 32'd1);
        check("freq_div_writes", 32'(write_cnt[8'h04] - b4), 32'd1);
        check("mod_index_writes", 32'(write_cnt[8'h08] - b8), 32'd1);

        // Randomized traffic with random response backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send(1'($urandom_range(0, 1)), 8'($urandom), 32'($urandom), 4'($urandom), 60);
            if ($urandom_range(0, 2) == 0) begin
                cmd_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        cmd_valid = 1'b0;
        drain(400);
        rand_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("final_rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
        check("final_bus_queue_empty", 32'(bus_q.size()), 32'd0);
        check("final_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone initiator for the inverter SoC peripheral bus. It takes register read/write commands from a valid/ready command port (DMA engine, protection sequencer or debug bridge), queues them in a small FIFO, and issues one single-beat Wishbone cycle per command. Each transaction's result is returned on a valid/ready response port. It is the master side of the registered one-cycle-ack handshake used by the PWM accelerator and the other bus peripherals.

## Interface
- ADDR_WIDTH, 8, width of cmd_addr and wb_addr.
- FIFO_DEPTH, 4, command FIFO entries; power of 2, at least 2.
- TIMEOUT_CYCLES, 255, maximum cycles wb_stb stays high without wb_ack; 2..65535.

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO not full (count < FIFO_DEPTH); registered-count only, no combinational path from inputs.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  32  write data.
- cmd_sel  in  4  byte selects.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumer ready.
- rsp_we  out  1  echo of the command's we.
- rsp_rdata  out  32  read data; 0 for writes and on error.
- rsp_err  out  1  transaction timed out.
- wb_addr  out  ADDR_WIDTH  bus address.
- wb_dat_o  out  32  bus write data.
- wb_dat_i  in  32  bus read data.
- wb_we  out  1  bus write enable.
- wb_sel  out  4  bus byte selects.
- wb_stb  out  1  strobe.
- wb_cyc  out  1  cycle; always equal to wb_stb.
- wb_ack  in  1  slave acknowledge.
- busy  out  1  state != IDLE or FIFO non-empty.

## Operation
- **Command accept:** push on cmd_valid && cmd_ready. The FIFO stores {we, sel, addr, wdata}, ADDR_WIDTH+37 bits.
- **Simultaneous push and pop:** both happen in the same cycle and the count is unchanged.
- **FSM states:** IDLE, REQ, RESP.
- **IDLE:** if the FIFO is non-empty, pop the head and load wb_addr/wb_dat_o/wb_we/wb_sel from it. Set wb_stb=wb_cyc=1, clear the timeout counter, and go to REQ.
- **REQ:**
  - If wb_ack=1: drop wb_stb/wb_cyc and go to RESP.
    - Read: latch rsp_rdata=wb_dat_i.
    - Write: rsp_rdata=0.
    - rsp_err=0.
  - Else, if counter == TIMEOUT_CYCLES-1: drop wb_stb/wb_cyc, set rsp_err=1 and rsp_rdata=0, and go to RESP.
  - Else: increment the counter.
  - If ack arrives in the final timeout cycle, ack wins and rsp_err=0.
- **RESP:**
  - rsp_valid=1; rsp_we/rsp_rdata/rsp_err are held stable.
  - When rsp_ready=1, clear rsp_valid and go to IDLE.
  - wb_stb stays 0 throughout.
- **Ack outside REQ** (late ack after timeout, spurious ack) is ignored and has no state effect.
- **Ordering:** responses come back in command order, one outstanding bus transaction at a time.
- **wb_* hold rule:** wb_addr/wb_dat_o/wb_we/wb_sel hold their value after the strobe drops, until the next pop.
- **Reset values:** all outputs 0 except cmd_ready=1. The FIFO empties and the FSM goes to IDLE.
- **Reset mid-transaction:** wb_stb/wb_cyc drop asynchronously. The pending command and all queued commands are discarded and no response is produced.

## Timing
- **Bus cycle:** let E0 be the accept edge into an empty FIFO with the FSM in IDLE.
  - E1: pop; wb_stb=1.
  - E2: a one-cycle-ack slave raises wb_ack.
  - E3: wb_stb=0 and rsp_valid=1.
- **Latency:** command to rsp_valid is 3 edges. wb_stb is high for exactly 2 cycles against the one-cycle-ack slave.
- **Strobe gap:** with rsp_ready held high, consecutive strobes are separated by at least 2 low cycles, which guarantees the slave's ack has fallen before the next strobe.
- **Timeout:** the timeout path keeps wb_stb high exactly TIMEOUT_CYCLES cycles.
- **Backpressure:** when rsp_ready is low, no new bus cycle starts.

## Test plan
- **Single write:** write addr 0x00, data 0x00000001, sel 0xF, against a one-cycle-ack slave model.
  - wb_stb high exactly 2 cycles with wb_we=1 and wb_dat_o=0x00000001.
  - rsp_valid at E3 with rsp_err=0, rsp_we=1, rsp_rdata=0.
  - Slave sees exactly one write.
- **Single read:** read addr 0x08 with the slave returning 0x00001234.
  - rsp_rdata=0x00001234, rsp_we=0, rsp_err=0.
- **FIFO backpressure (FIFO_DEPTH=4):** hold rsp_ready=0 and drive 6 commands with cmd_valid held high.
  - 5 accepted (1 in flight plus 4 queued), then cmd_ready=0 and the 6th stalls.
  - Release rsp_ready: 6 responses in issue order with the correct addresses.
  - No overlapping strobes.
- **Timeout (TIMEOUT_CYCLES=16):** slave never acks.
  - wb_stb high exactly 16 cycles, then rsp_err=1 and rsp_rdata=0.
  - An ack injected 3 cycles later is ignored, and the next command completes normally.
- **Reset mid-transaction:** assert rst_n low while wb_stb=1 with 2 commands queued.
  - wb_stb/wb_cyc/rsp_valid go 0 immediately and cmd_ready=1.
  - After release, no bus cycle occurs until a new command arrives.
- **Streamed writes:** 3 writes with rsp_ready=1 to the PWM register map (CTRL, FREQ_DIV, MOD_INDEX).
  - Each register is written exactly once.
  - Strobe low gaps are at least 2 cycles.
  - busy falls 1 cycle after the last response handshake.
